// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the boot/run controller and the processor's
// program RAM.
package prog_loader_pkg;
  localparam int PL_ADDR_W = 8;
  localparam int PL_DATA_W = 8;
  localparam int CC_W      = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_RUN,
    ST_DONE
  } state_e;
endpackage

// File: rtl/prog_loader_if.sv
// Control, byte-source, program-RAM and processor signals of the loader.
// slave = loader side, master = the environment driving it.
interface prog_loader_if
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W = PL_ADDR_W,
  parameter int DATA_W = PL_DATA_W
);
  logic              start;
  logic [ADDR_W:0]   len;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              cpu_en;
  logic              cpu_halt;
  logic [CC_W-1:0]   cpu_cc;
  logic              busy;
  logic              done;
  logic              timeout;
  logic [CC_W-1:0]   cc_out;

  modport slave (
    input  start, len, in_valid, in_data, cpu_halt, cpu_cc,
    output in_ready, mem_we, mem_addr, mem_wdata, cpu_en, busy, done,
           timeout, cc_out
  );

  modport master (
    output start, len, in_valid, in_data, cpu_halt, cpu_cc,
    input  in_ready, mem_we, mem_addr, mem_wdata, cpu_en, busy, done,
           timeout, cc_out
  );
endinterface

// File: rtl/prog_loader_run_watchdog.sv
// Run-length watchdog: counts enabled cycles from 0 and flags the cycle in
// which the count reaches WDOG_CYCLES-1.
module run_watchdog
  import prog_loader_pkg::*;
#(
  parameter logic [CC_W-1:0] WDOG_CYCLES = 16'd4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic cnt_en,
  output logic tc
);
  logic [CC_W-1:0] cnt_q, cnt_d;

  // Clear dominates; otherwise count while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clear)       cnt_d = '0;
    else if (cnt_en) cnt_d = cnt_q + CC_W'(1);
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tc = cnt_en && (cnt_q == WDOG_CYCLES - CC_W'(1));
endmodule

// File: rtl/prog_loader.sv
// Boot/run controller: streams a program image into program RAM, holds the
// processor idle for one settle cycle, runs it, and captures its cycle
// counter on halt or watchdog expiry.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int              ADDR_W      = PL_ADDR_W,
  parameter int              DATA_W      = PL_DATA_W,
  parameter logic [CC_W-1:0] WDOG_CYCLES = 16'd4096
) (
  input logic         clk,
  input logic         rst_n,
  prog_loader_if.slave bus
);
  // Largest image the RAM can hold; longer requests are clipped to this.
  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic              timeout_q, timeout_d;
  logic [CC_W-1:0]   cc_q, cc_d;
  logic              cpu_en_q, cpu_en_d;
  logic [ADDR_W:0]   len_sat;
  logic              xfer;
  logic              last_xfer;
  logic              wd_tc;

  assign len_sat   = (bus.len > MAX_LEN) ? MAX_LEN : bus.len;
  assign xfer      = (state_q == ST_LOAD) && bus.in_valid;
  assign last_xfer = ({1'b0, addr_q} == len_q - (ADDR_W+1)'(1));

  run_watchdog #(.WDOG_CYCLES(WDOG_CYCLES)) u_wdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state_q != ST_RUN),
    .cnt_en (state_q == ST_RUN),
    .tc     (wd_tc)
  );

  // Next-state and captured-result logic.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    timeout_d = timeout_q;
    cc_d      = cc_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          len_d     = len_sat;
          addr_d    = '0;
          timeout_d = 1'b0;
          // A zero-length start reruns whatever image is already in RAM.
          state_d   = (len_sat == '0) ? ST_SETTLE : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (xfer) begin
          addr_d = addr_q + ADDR_W'(1);
          if (last_xfer) state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: state_d = ST_RUN;
      ST_RUN: begin
        // Halt takes priority so a program finishing on the last allowed
        // cycle is not reported as a timeout.
        if (bus.cpu_halt) begin
          cc_d      = bus.cpu_cc;
          timeout_d = 1'b0;
          state_d   = ST_DONE;
        end else if (wd_tc) begin
          cc_d      = bus.cpu_cc;
          timeout_d = 1'b1;
          state_d   = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    cpu_en_d = (state_d == ST_RUN);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      timeout_q <= 1'b0;
      cc_q      <= '0;
      cpu_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      timeout_q <= timeout_d;
      cc_q      <= cc_d;
      cpu_en_q  <= cpu_en_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_LOAD);
  assign bus.mem_we    = xfer;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = bus.in_data;
  assign bus.cpu_en    = cpu_en_q;
  assign bus.busy      = (state_q == ST_LOAD) || (state_q == ST_SETTLE) ||
                         (state_q == ST_RUN);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.timeout   = timeout_q;
  assign bus.cc_out    = cc_q;
endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: dut_a uses the default watchdog, dut_b a short
// 8-cycle watchdog. Expected RAM writes and end-of-run results are queued by
// the stimulus and popped by a negedge monitor.
module tb_prog_loader;
  import prog_loader_pkg::*;

  localparam int AW = 8;
  localparam int DW = 8;

  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
  typedef struct { logic to; logic [15:0] cc; } dn_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  prog_loader_if #(.ADDR_W(AW), .DATA_W(DW)) if_a ();
  prog_loader_if #(.ADDR_W(AW), .DATA_W(DW)) if_b ();

  prog_loader #(.ADDR_W(AW), .DATA_W(DW), .WDOG_CYCLES(16'd4096)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(if_a));
  prog_loader #(.ADDR_W(AW), .DATA_W(DW), .WDOG_CYCLES(16'd8)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(if_b));

  wr_t wr_q[$];
  dn_t dn_a_q[$];
  dn_t dn_b_q[$];
  int  n_vec = 0;
  int  n_err = 0;
  int  n_wr  = 0;
  logic done_a_prev = 1'b0;
  logic done_b_prev = 1'b0;
  wr_t ew;
  dn_t ed;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every write and every completed run must match the
  // head of its expectation queue.
  always @(negedge clk) begin
    if (if_a.mem_we === 1'b1) begin
      n_wr++;
      if (wr_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_write: addr %0h data %0h", if_a.mem_addr, if_a.mem_wdata);
      end else begin
        ew = wr_q.pop_front();
        chk("wr_addr", 32'(if_a.mem_addr), 32'(ew.addr));
        chk("wr_data", 32'(if_a.mem_wdata), 32'(ew.data));
      end
    end
    if (if_b.mem_we === 1'b1) begin
      n_vec++; n_err++;
      $display("FAIL unexpected_write_b: addr %0h", if_b.mem_addr);
    end
    if (if_a.done === 1'b1 && !done_a_prev) begin
      if (dn_a_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_done_a: cc %0h", if_a.cc_out);
      end else begin
        ed = dn_a_q.pop_front();
        chk("a_timeout", 32'(if_a.timeout), 32'(ed.to));
        chk("a_cc_out", 32'(if_a.cc_out), 32'(ed.cc));
        chk("a_done_cpu_en", 32'(if_a.cpu_en), 32'd0);
        chk("a_done_busy", 32'(if_a.busy), 32'd0);
      end
    end
    if (if_b.done === 1'b1 && !done_b_prev) begin
      if (dn_b_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_done_b: cc %0h", if_b.cc_out);
      end else begin
        ed = dn_b_q.pop_front();
        chk("b_timeout", 32'(if_b.timeout), 32'(ed.to));
        chk("b_cc_out", 32'(if_b.cc_out), 32'(ed.cc));
        chk("b_done_cpu_en", 32'(if_b.cpu_en), 32'd0);
      end
    end
    done_a_prev = (if_a.done === 1'b1);
    done_b_prev = (if_b.done === 1'b1);
  end

  initial begin
    int k;
    int run_cnt;
    {if_a.start, if_a.len, if_a.in_valid, if_a.in_data, if_a.cpu_halt, if_a.cpu_cc} = '0;
    {if_b.start, if_b.len, if_b.in_valid, if_b.in_data, if_b.cpu_halt, if_b.cpu_cc} = '0;

    // Reset state
    rst_n = 1'b0; tick(); tick();
    chk("rst_cpu_en", 32'(if_a.cpu_en), 0);
    chk("rst_in_ready", 32'(if_a.in_ready), 0);
    chk("rst_mem_we", 32'(if_a.mem_we), 0);
    chk("rst_busy", 32'(if_a.busy), 0);
    chk("rst_done", 32'(if_a.done), 0);
    chk("rst_timeout", 32'(if_a.timeout), 0);
    chk("rst_cc_out", 32'(if_a.cc_out), 0);
    rst_n = 1'b1; tick();

    // 3-byte load with a 2-cycle gap; a start pulse inside the gap is ignored
    if_a.len = 9'd3; if_a.start = 1'b1; tick(); if_a.start = 1'b0;
    chk("load_in_ready", 32'(if_a.in_ready), 1);
    chk("load_busy", 32'(if_a.busy), 1);
    wr_q.push_back('{8'h00, 8'hA0});
    wr_q.push_back('{8'h01, 8'hB1});
    wr_q.push_back('{8'h02, 8'hC2});
    if_a.in_valid = 1'b1; if_a.in_data = 8'hA0; tick();
    if_a.in_valid = 1'b0; if_a.in_data = 8'hEE;
    if_a.start = 1'b1; if_a.len = 9'd5; tick(); if_a.start = 1'b0; tick();
    if_a.in_valid = 1'b1; if_a.in_data = 8'hB1; tick();
    if_a.in_data = 8'hC2; tick();
    if_a.in_valid = 1'b0;
    chk("settle_cpu_en", 32'(if_a.cpu_en), 0);
    chk("settle_in_ready", 32'(if_a.in_ready), 0);
    chk("settle_busy", 32'(if_a.busy), 1);
    tick();
    chk("run1_cpu_en", 32'(if_a.cpu_en), 1);

    // Halt on RUN cycle 10; a start pulse on cycle 3 is ignored
    repeat (2) tick();
    if_a.start = 1'b1; if_a.len = 9'd0; tick(); if_a.start = 1'b0;
    repeat (6) tick();
    chk("run10_cpu_en", 32'(if_a.cpu_en), 1);
    if_a.cpu_halt = 1'b1; if_a.cpu_cc = 16'h0123;
    dn_a_q.push_back('{1'b0, 16'h0123});
    tick(); if_a.cpu_halt = 1'b0; if_a.cpu_cc = 16'h0000;
    chk("halt_done", 32'(if_a.done), 1);
    tick();
    chk("hold_cc_out", 32'(if_a.cc_out), 32'h0123);
    chk("hold_done", 32'(if_a.done), 1);

    // len=0: straight to SETTLE, cc_out held until next capture
    if_a.len = 9'd0; if_a.start = 1'b1; tick(); if_a.start = 1'b0;
    chk("len0_in_ready", 32'(if_a.in_ready), 0);
    chk("len0_cpu_en", 32'(if_a.cpu_en), 0);
    chk("len0_busy", 32'(if_a.busy), 1);
    chk("len0_done", 32'(if_a.done), 0);
    chk("len0_cc_held", 32'(if_a.cc_out), 32'h0123);
    tick();
    chk("len0_run", 32'(if_a.cpu_en), 1);
    if_a.cpu_halt = 1'b1; if_a.cpu_cc = 16'h0777;
    dn_a_q.push_back('{1'b0, 16'h0777});
    tick(); if_a.cpu_halt = 1'b0;

    // len=300 saturates to 256 writes, final address 255
    if_a.len = 9'd300; if_a.start = 1'b1; tick(); if_a.start = 1'b0;
    for (int i = 0; i < 256; i++) wr_q.push_back('{8'(i), 8'(i) ^ 8'h5A});
    if_a.in_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      if_a.in_data = 8'(i) ^ 8'h5A;
      tick();
    end
    if_a.in_data = 8'hFF;
    chk("sat_settle_in_ready", 32'(if_a.in_ready), 0);
    chk("sat_settle_cpu_en", 32'(if_a.cpu_en), 0);
    tick();
    chk("sat_run_cpu_en", 32'(if_a.cpu_en), 1);
    if_a.in_valid = 1'b0;
    if_a.cpu_halt = 1'b1; if_a.cpu_cc = 16'h1234;
    dn_a_q.push_back('{1'b0, 16'h1234});
    tick(); if_a.cpu_halt = 1'b0;

    // Reset after the 2nd byte of a 4-byte load
    if_a.len = 9'd4; if_a.start = 1'b1; tick(); if_a.start = 1'b0;
    wr_q.push_back('{8'h00, 8'h11});
    wr_q.push_back('{8'h01, 8'h22});
    if_a.in_valid = 1'b1; if_a.in_data = 8'h11; tick();
    if_a.in_data = 8'h22; tick();
    if_a.in_valid = 1'b0;
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("abort_cpu_en", 32'(if_a.cpu_en), 0);
    chk("abort_in_ready", 32'(if_a.in_ready), 0);
    chk("abort_busy", 32'(if_a.busy), 0);
    chk("abort_done", 32'(if_a.done), 0);
    chk("abort_cc_out", 32'(if_a.cc_out), 0);
    chk("write_count", 32'(n_wr), 32'd261);

    // Watchdog expiry on dut_b (8 cycles)
    tick();
    if_b.len = 9'd0; if_b.cpu_cc = 16'h0040;
    if_b.start = 1'b1; tick(); if_b.start = 1'b0;
    tick();
    dn_b_q.push_back('{1'b1, 16'h0040});
    k = 0; run_cnt = 0;
    while (if_b.done !== 1'b1 && k < 20) begin
      if (if_b.cpu_en === 1'b1) run_cnt++;
      tick(); k++;
    end
    chk("wd_done", 32'(if_b.done), 1);
    chk("wd_run_cycles", 32'(run_cnt), 32'd8);
    chk("wd_timeout", 32'(if_b.timeout), 1);

    // Halt and watchdog expiry on the same cycle: halt wins
    if_b.cpu_cc = 16'h0055;
    if_b.start = 1'b1; tick(); if_b.start = 1'b0;
    chk("co_start_clears_to", 32'(if_b.timeout), 0);
    tick();
    repeat (7) tick();
    chk("co_run8_cpu_en", 32'(if_b.cpu_en), 1);
    if_b.cpu_halt = 1'b1;
    dn_b_q.push_back('{1'b0, 16'h0055});
    tick(); if_b.cpu_halt = 1'b0;
    chk("co_done", 32'(if_b.done), 1);
    chk("co_timeout", 32'(if_b.timeout), 0);
    tick();

    chk("wr_pending", 32'(wr_q.size()), 0);
    chk("dn_a_pending", 32'(dn_a_q.size()), 0);
    chk("dn_b_pending", 32'(dn_b_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
